// File: rtl/bcd_scan_driver_if.sv
// Bus between the BPM source and the 3-digit display driver: load
// handshake, converted digits and the digit-select scan code.
interface bcd_scan_driver_if;
    logic [7:0] bin_in;
    logic       load;
    logic       busy;
    logic       done;
    logic [3:0] dig_hund;
    logic [3:0] dig_tens;
    logic [3:0] dig_ones;
    logic [1:0] selec;

    // Producer side: supplies the value and strobe, watches status and digits
    modport master (
        output bin_in,
        output load,
        input  busy,
        input  done,
        input  dig_hund,
        input  dig_tens,
        input  dig_ones,
        input  selec
    );

    // Driver side: consumes the value and strobe, produces status and digits
    modport slave (
        input  bin_in,
        input  load,
        output busy,
        output done,
        output dig_hund,
        output dig_tens,
        output dig_ones,
        output selec
    );
endinterface

// File: rtl/bcd_scan_driver.sv
// 8-bit binary to 3-digit BCD converter (sequential double-dabble, one
// bit per cycle) with optional leading-zero blanking, plus a free-running
// digit-select scan generator for a multiplexed 7-segment display.
// A blanked digit is 4'hF, which the downstream decoder shows as all-off.
module bcd_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic          clk,
    input logic          reset,
    bcd_scan_driver_if.slave bus
);

    localparam int               CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(REFRESH_DIV - 1);
    localparam logic [3:0]       LZ_RESET = BLANK_LZ ? 4'hF : 4'h0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]       state;
    logic [7:0]       shift_reg;
    logic [11:0]      scratch;
    logic [2:0]       iter;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       hund_r;
    logic [3:0]       tens_r;
    logic [3:0]       ones_r;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       selec_r;

    logic [11:0]      scratch_adj;
    logic [19:0]      shifted;
    logic             blank_hund;
    logic             blank_tens;
    logic [3:0]       next_hund;
    logic [3:0]       next_tens;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // One double-dabble step: correct each BCD nibble, then shift the
    // combined {scratch, shift_reg} word left by one bit
    always_comb begin
        scratch_adj = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        shifted     = {scratch_adj, shift_reg} << 1;
    end

    // Leading-zero blanking of the finished result; tens only blank when
    // hundreds is also blank, so 100 still shows its middle zero
    always_comb begin
        blank_hund = BLANK_LZ && (scratch[11:8] == 4'd0);
        blank_tens = blank_hund && (scratch[7:4] == 4'd0);
        next_hund  = blank_hund ? 4'hF : scratch[11:8];
        next_tens  = blank_tens ? 4'hF : scratch[7:4];
    end

    // Conversion FSM: accept in IDLE, eight shift cycles, then publish the
    // digits together with a one-cycle done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            shift_reg <= 8'd0;
            scratch   <= 12'd0;
            iter      <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            hund_r    <= LZ_RESET;
            tens_r    <= LZ_RESET;
            ones_r    <= 4'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.load) begin
                        shift_reg <= bus.bin_in;
                        scratch   <= 12'd0;
                        iter      <= 3'd0;
                        busy_r    <= 1'b1;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch   <= shifted[19:8];
                    shift_reg <= shifted[7:0];
                    iter      <= iter + 3'd1;
                    if (iter == 3'd7) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    hund_r <= next_hund;
                    tens_r <= next_tens;
                    ones_r <= scratch[3:0];
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running refresh divider; the scan code steps on each wrap and
    // never produces 2'b11 (an unexpected 11 recovers to 00)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            selec_r     <= 2'b00;
        end else if (refresh_cnt == CNT_TERM) begin
            refresh_cnt <= '0;
            case (selec_r)
                2'b00:   selec_r <= 2'b01;
                2'b01:   selec_r <= 2'b10;
                default: selec_r <= 2'b00;
            endcase
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.dig_hund = hund_r;
    assign bus.dig_tens = tens_r;
    assign bus.dig_ones = ones_r;
    assign bus.selec    = selec_r;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed bench for bcd_scan_driver: two instances sharing clock, reset
// and stimulus, one with leading-zero blanking and one without, both
// with a short refresh divider so the scan sequence is quick to observe.
module tb_bcd_scan_driver;

    logic       clk;
    logic       reset;
    logic [7:0] bin_drv;
    logic       load_drv;

    int n_checks;
    int n_fails;

    bcd_scan_driver_if if_a ();
    bcd_scan_driver_if if_b ();

    assign if_a.bin_in = bin_drv;
    assign if_a.load   = load_drv;
    assign if_b.bin_in = bin_drv;
    assign if_b.load   = load_drv;

    bcd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    bcd_scan_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything above ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] digits_a();
        return {if_a.dig_hund, if_a.dig_tens, if_a.dig_ones};
    endfunction

    function automatic logic [11:0] digits_b();
        return {if_b.dig_hund, if_b.dig_tens, if_b.dig_ones};
    endfunction

    // Strobe load for one edge; returns just after the accepting edge
    task automatic start_load(input logic [7:0] v);
        bin_drv  = v;
        load_drv = 1'b1;
        tick();
        load_drv = 1'b0;
    endtask

    // Waits (bounded) for done; counts busy samples and watches digit stability
    task automatic wait_done(output int busy_cycles, output bit stable_ok, output bit timed_out);
        logic [11:0] pre;
        int n;
        pre         = digits_a();
        busy_cycles = 0;
        stable_ok   = 1'b1;
        n           = 0;
        while (!if_a.done && n < 20) begin
            if (if_a.busy) busy_cycles++;
            if (digits_a() !== pre) stable_ok = 1'b0;
            tick();
            n++;
        end
        timed_out = !if_a.done;
    endtask

    // Full conversion with latency, status and result checks on both instances
    task automatic run_conv(input logic [7:0] v, input logic [11:0] exp_a,
                            input logic [11:0] exp_b, input string tag);
        int bc;
        bit st;
        bit to;
        start_load(v);
        wait_done(bc, st, to);
        check({tag, " done seen"}, {11'd0, ~to}, 12'd1);
        check({tag, " busy cycles"}, 12'(bc), 12'd9);
        check({tag, " digits stable"}, {11'd0, st}, 12'd1);
        check({tag, " busy low at done"}, {11'd0, if_a.busy}, 12'd0);
        check({tag, " digits blank"}, digits_a(), exp_a);
        check({tag, " digits noblank"}, digits_b(), exp_b);
        check({tag, " done noblank"}, {11'd0, if_b.done}, 12'd1);
        tick();
        check({tag, " done pulse ends"}, {11'd0, if_a.done}, 12'd0);
    endtask

    initial begin
        int bc;
        bit st;
        bit to;
        bit done_seen;
        logic [1:0] exp_sel;

        n_checks = 0;
        n_fails  = 0;
        reset    = 1'b1;
        bin_drv  = 8'd0;
        load_drv = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {11'd0, if_a.busy}, 12'd0);
        check("reset done", {11'd0, if_a.done}, 12'd0);
        check("reset digits blank", digits_a(), 12'hFF0);
        check("reset digits noblank", digits_b(), 12'h000);
        check("reset selec", {10'd0, if_a.selec}, 12'd0);

        // Scan sequence from a fresh reset, with a load in the middle
        reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            exp_sel = 2'(((k + 1) / 4) % 3);
            check($sformatf("scan a k=%0d", k), {10'd0, if_a.selec}, {10'd0, exp_sel});
            check($sformatf("scan b k=%0d", k), {10'd0, if_b.selec}, {10'd0, exp_sel});
            if (k == 5) begin
                bin_drv  = 8'd77;
                load_drv = 1'b1;
            end else begin
                load_drv = 1'b0;
            end
        end
        check("load during scan", digits_a(), 12'hF77);

        // Main conversions
        run_conv(8'd72,  12'hF72, 12'h072, "bin72");
        run_conv(8'd255, 12'h255, 12'h255, "bin255");
        run_conv(8'd0,   12'hFF0, 12'h000, "bin0");
        run_conv(8'd100, 12'h100, 12'h100, "bin100");
        run_conv(8'd9,   12'hFF9, 12'h009, "bin9");
        run_conv(8'd5,   12'hFF5, 12'h005, "bin5");

        // Load while busy is ignored; next accept right after done
        start_load(8'd60);
        tick();
        bin_drv  = 8'd180;
        load_drv = 1'b1;
        tick();
        load_drv = 1'b0;
        bin_drv  = 8'd0;
        wait_done(bc, st, to);
        check("busy-ignore done seen", {11'd0, ~to}, 12'd1);
        check("busy-ignore busy cycles", 12'(bc), 12'd7);
        check("busy-ignore result", digits_a(), 12'hF60);
        start_load(8'd180);
        check("accept at E10 busy", {11'd0, if_a.busy}, 12'd1);
        wait_done(bc, st, to);
        check("accept at E10 done seen", {11'd0, ~to}, 12'd1);
        check("accept at E10 busy cycles", 12'(bc), 12'd9);
        check("accept at E10 result", digits_a(), 12'h180);
        tick();

        // Reset in the middle of SHIFT aborts the conversion
        start_load(8'd123);
        repeat (3) tick();
        check("midshift busy before reset", {11'd0, if_a.busy}, 12'd1);
        reset = 1'b1;
        #1;
        check("midshift reset busy", {11'd0, if_a.busy}, 12'd0);
        check("midshift reset done", {11'd0, if_a.done}, 12'd0);
        check("midshift reset digits blank", digits_a(), 12'hFF0);
        check("midshift reset digits noblank", digits_b(), 12'h000);
        tick();
        reset     = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (if_a.done || if_b.done) done_seen = 1'b1;
        end
        check("midshift no done after release", {11'd0, done_seen}, 12'd0);
        check("midshift digits after release", digits_a(), 12'hFF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule
